// File: rtl/button_event_arbiter.sv
// Debounced multi-button front end that funnels presses into one
// round-robin valid/ack event channel.

module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic held,
  output logic rise
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             s;
  logic             flip;

  assign s    = sync[1];
  // Accept the new level on the DEBOUNCE_CYCLES-th consecutive disagreeing edge.
  assign flip = (s != held) && (cnt == CNT_LAST);
  assign rise = flip && s;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      cnt  <= '0;
      held <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (s == held || flip) cnt <= '0;
      else                   cnt <= cnt + 1'b1;
      if (flip) held <= s;
    end
  end
endmodule

module button_event_arbiter #(
  parameter int N_BTN           = 4,
  parameter int ID_W            = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             CLK_FPGA,
  input  logic             Reset,
  input  logic [N_BTN-1:0] Btn,
  input  logic             Ack,
  output logic             EvtValid,
  output logic [ID_W-1:0]  EvtId,
  output logic [N_BTN-1:0] Held,
  output logic             Overflow
);
  typedef enum logic {IDLE, PRESENT} state_t;

  state_t           state, state_next;
  logic [N_BTN-1:0] rise, pend, pend_next, clr, drop;
  logic [ID_W-1:0]  ptr, ptr_next, id_next, pick_id;
  logic             found;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk  (CLK_FPGA),
      .reset(Reset),
      .raw  (Btn[gi]),
      .held (Held[gi]),
      .rise (rise[gi])
    );
  end

  // First pending bit at or above ptr, wrapping modulo N_BTN.
  always_comb begin
    int j;
    j       = 0;
    found   = 1'b0;
    pick_id = '0;
    for (int k = 0; k < N_BTN; k++) begin
      j = (int'(ptr) + k) % N_BTN;
      if (!found && pend[j]) begin
        found   = 1'b1;
        pick_id = ID_W'(j);
      end
    end
  end

  always_comb begin
    state_next = state;
    id_next    = EvtId;
    ptr_next   = ptr;
    clr        = '0;
    EvtValid   = (state == PRESENT);
    case (state)
      IDLE: begin
        if (found) begin
          id_next    = pick_id;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (Ack) begin
          for (int i = 0; i < N_BTN; i++) clr[i] = (EvtId == ID_W'(i));
          ptr_next   = (EvtId == ID_W'(N_BTN - 1)) ? '0 : EvtId + 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A press wins over a same-edge clear, so it is neither lost nor counted as a drop.
  assign drop      = rise & pend & ~clr;
  assign pend_next = (pend & ~clr) | rise;

  always_ff @(posedge CLK_FPGA) begin
    if (Reset) begin
      state    <= IDLE;
      EvtId    <= '0;
      ptr      <= '0;
      pend     <= '0;
      Overflow <= 1'b0;
    end else begin
      state    <= state_next;
      EvtId    <= id_next;
      ptr      <= ptr_next;
      pend     <= pend_next;
      Overflow <= |drop;
    end
  end
endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench: a window-based reference model predicts every cycle's
// outputs; a negedge monitor pops and compares them against the DUT.

module tb_button_event_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int DEB = 4;
  localparam int CW  = 3;

  logic           CLK_FPGA = 1'b0;
  logic           Reset, Ack, EvtValid, Overflow;
  logic [N-1:0]   Btn, Held;
  logic [IDW-1:0] EvtId;

  typedef struct packed {
    logic           rst;
    logic           valid;
    logic [IDW-1:0] id;
    logic [N-1:0]   held;
    logic           ovf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  button_event_arbiter #(
    .N_BTN(N), .ID_W(IDW), .DEBOUNCE_CYCLES(DEB), .CNT_W(CW)
  ) dut (
    .CLK_FPGA(CLK_FPGA), .Reset(Reset), .Btn(Btn), .Ack(Ack),
    .EvtValid(EvtValid), .EvtId(EvtId), .Held(Held), .Overflow(Overflow)
  );

  always #5 CLK_FPGA = ~CLK_FPGA;

  // Reference model: a level is accepted once the last DEB synchronized samples
  // all disagree with it; pending presses are served round-robin.
  logic [N-1:0]   m_s1 = '0, m_s2 = '0, m_held = '0, m_pend = '0;
  logic [DEB-1:0] win [N];
  int             fill [N];
  bit             m_pres = 0;
  int             m_pid = 0, m_ptr = 0;

  always @(posedge CLK_FPGA) begin : model
    exp_t         e;
    logic [N-1:0] s_pre, new_held, rise, cleared;
    int           idx;
    bit           got;
    e = '0;
    if (Reset) begin
      m_s1 = '0; m_s2 = '0; m_held = '0; m_pend = '0;
      m_pres = 0; m_pid = 0; m_ptr = 0;
      for (int i = 0; i < N; i++) begin win[i] = '0; fill[i] = 0; end
      e.rst = 1'b1;
    end else begin
      s_pre = m_s2; m_s2 = m_s1; m_s1 = Btn;
      new_held = m_held;
      for (int i = 0; i < N; i++) begin
        win[i] = {win[i][DEB-2:0], s_pre[i]};
        if (fill[i] < DEB) fill[i]++;
        if (fill[i] == DEB && win[i] == {DEB{~m_held[i]}}) begin
          new_held[i] = ~m_held[i];
          fill[i] = 0;
        end
      end
      rise    = new_held & ~m_held;
      cleared = '0;
      if (m_pres) begin
        if (Ack) begin
          cleared[m_pid] = 1'b1;
          m_ptr  = (m_pid + 1) % N;
          m_pres = 0;
        end
      end else begin
        got = 0;
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (!got && m_pend[idx]) begin got = 1; m_pid = idx; end
        end
        m_pres = got;
      end
      e.ovf   = |(rise & m_pend & ~cleared);
      m_pend  = (m_pend & ~cleared) | rise;
      m_held  = new_held;
      e.valid = m_pres;
      e.id    = IDW'(m_pid);
      e.held  = m_held;
    end
    q.push_back(e);
  end

  always @(negedge CLK_FPGA) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (EvtValid !== e.valid || ((e.valid || e.rst) && EvtId !== e.id) ||
          Held !== e.held || Overflow !== e.ovf) begin
        errors++;
        $display("FAIL outputs t=%0t got valid=%0b id=%0d held=%b ovf=%0b expected valid=%0b id=%0d held=%b ovf=%0b",
                 $time, EvtValid, EvtId, Held, Overflow, e.valid, e.id, e.held, e.ovf);
      end
    end
  end

  task automatic cyc(input logic [N-1:0] b, input logic a, input logic r);
    Btn = b; Ack = a; Reset = r;
    @(negedge CLK_FPGA);
  endtask

  initial begin
    logic [N-1:0] b;
    repeat (3)  cyc('0, 1'b0, 1'b1);
    repeat (20) cyc('0, 1'b0, 1'b0);
    // single press, ack at edge 8
    for (int c = 0; c < 20; c++) cyc(4'b0001, c == 8, 1'b0);
    repeat (15) cyc('0, 1'b1, 1'b0);
    // bouncing button 1
    for (int c = 0; c < 5; c++) cyc((c % 2 == 0) ? 4'b0010 : 4'b0000, 1'b1, 1'b0);
    repeat (15) cyc(4'b0010, 1'b1, 1'b0);
    repeat (15) cyc('0, 1'b1, 1'b0);
    // all buttons, ack tied high, then wrap back to button 0
    repeat (20) cyc(4'b1111, 1'b1, 1'b0);
    repeat (10) cyc('0, 1'b1, 1'b0);
    repeat (12) cyc(4'b0001, 1'b1, 1'b0);
    repeat (10) cyc('0, 1'b1, 1'b0);
    // overflow on a second press while still pending
    repeat (10) cyc(4'b0100, 1'b0, 1'b0);
    repeat (10) cyc('0, 1'b0, 1'b0);
    repeat (10) cyc(4'b0100, 1'b0, 1'b0);
    repeat (10) cyc(4'b0100, 1'b1, 1'b0);
    repeat (10) cyc('0, 1'b0, 1'b0);
    // re-press lands on the same edge as the ack of the earlier press
    for (int c = 0; c < 30; c++)
      cyc((c < 6 || c >= 12) ? 4'b0100 : 4'b0000, (c == 17) || (c >= 22), 1'b0);
    repeat (10) cyc('0, 1'b1, 1'b0);
    // reset while presenting, button held through it
    repeat (8)  cyc(4'b1000, 1'b0, 1'b0);
    cyc(4'b1000, 1'b0, 1'b1);
    repeat (12) cyc(4'b1000, 1'b0, 1'b0);
    cyc(4'b1000, 1'b1, 1'b0);
    repeat (10) cyc('0, 1'b1, 1'b0);
    // random traffic
    b = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) b[i] = ~b[i];
      cyc(b, $urandom_range(0, 2) == 0, $urandom_range(0, 299) == 0);
    end
    repeat (12) cyc('0, 1'b1, 1'b0);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d queued expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
